// File: rtl/cpu_pkg.sv
// Shared register-file definitions for the CPU writeback path.
//
// Contents:
//   REG_ADR_W, REG_DATA_W  register-file address and data widths (64x64)
//   wb_req_t               one register-file write: destination and data
//   wb_src_t               which source owns the write port in a cycle
//   makeReq                packs an address/data pair into a wb_req_t
package cpu_pkg;

    localparam int REG_ADR_W  = 6;
    localparam int REG_DATA_W = 64;

    typedef struct packed {
        logic [REG_ADR_W-1:0]  adr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_t;

    function automatic wb_req_t makeReq(input logic [REG_ADR_W-1:0]  adr,
                                        input logic [REG_DATA_W-1:0] data);
        wb_req_t req;
        req.adr  = adr;
        req.data = data;
        return req;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding load results that lost write-port arbitration.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset, empties the FIFO
//   push      in   enqueue pushData at the next edge
//   pushData  in   entry to enqueue
//   pop       in   discard the head entry at the next edge
//   head      out  oldest entry (valid while count != 0)
//   count     out  number of stored entries, 0..DEPTH
//   full      out  count == DEPTH
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_req_t                      pushData,
    input  logic                         pop,
    output wb_req_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    wb_req_t           store [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;

    assign head = store[rdPtr];
    assign full = (count == CNT_FULL);

    // Entry storage carries no reset: stale data is never visible because
    // count gates every use of the head.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wrPtr] <= pushData;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Occupancy must stay within 0..DEPTH.
    overflowCheck: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && full));

    underflowCheck: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == '0)));

endmodule

// File: rtl/writeback_arbiter.sv
// Producer side of the register-file write port.  Merges un-throttled ALU
// results and handshaked load results into one registered write per cycle,
// buffering loads that lose arbitration, and tracks which registers still
// await a load result.
//
// Ports:
//   clk, rst                         clock and asynchronous active-high reset
//   aluValid/aluAdr/aluData          ALU result, always accepted
//   memValid/memReady/memAdr/memData load result with valid/ready handshake
//   issueValid/issueAdr              a load to issueAdr was issued
//   writeAdr/writeData/writeEnable   registered register-file write port
//   pendingMask                      bit i set while a load to register i is outstanding
module writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADR_W  = REG_ADR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    aluValid,
    input  logic [ADR_W-1:0]        aluAdr,
    input  logic [DATA_W-1:0]       aluData,
    input  logic                    memValid,
    output logic                    memReady,
    input  logic [ADR_W-1:0]        memAdr,
    input  logic [DATA_W-1:0]       memData,
    input  logic                    issueValid,
    input  logic [ADR_W-1:0]        issueAdr,
    output logic [ADR_W-1:0]        writeAdr,
    output logic [DATA_W-1:0]       writeData,
    output logic                    writeEnable,
    output logic [(1<<ADR_W)-1:0]   pendingMask
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              readyArm;
    logic              memAccept;
    logic              fifoPush;
    logic              fifoPop;
    logic              fifoFull;
    logic [CNT_W-1:0]  fifoCount;
    wb_req_t           fifoHead;
    wb_req_t           aluReq;
    wb_req_t           memReq;
    wb_req_t           selReq;
    wb_src_t           selSrc;
    logic              clearEn;
    logic [(1<<ADR_W)-1:0] pendNext;

    assign aluReq = makeReq(aluAdr, aluData);
    assign memReq = makeReq(memAdr, memData);

    // readyArm keeps memReady low during reset and for the first cycle after
    // it, so no load is taken while the rest of the path is still settling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            readyArm <= 1'b0;
        end else begin
            readyArm <= 1'b1;
        end
    end

    // Ready depends only on registered state.  A full FIFO that is draining
    // this cycle still refuses a new load; it frees up one cycle later.
    assign memReady  = readyArm && !fifoFull;
    assign memAccept = memValid && memReady;

    // Write-port arbitration: ALU first, then the oldest buffered load, then
    // a fresh load straight through.  A fresh load that is not written is
    // buffered, so it is never both written and enqueued.
    always_comb begin
        selSrc   = SRC_NONE;
        selReq   = aluReq;
        fifoPush = 1'b0;
        fifoPop  = 1'b0;
        if (aluValid) begin
            selSrc   = SRC_ALU;
            fifoPush = memAccept;
        end else if (fifoCount != '0) begin
            selSrc   = SRC_FIFO;
            selReq   = fifoHead;
            fifoPop  = 1'b1;
            fifoPush = memAccept;
        end else if (memAccept) begin
            selSrc   = SRC_BYPASS;
            selReq   = memReq;
        end
    end

    wb_fifo #(
        .DEPTH    (DEPTH)
    ) loadFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pushData (memReq),
        .pop      (fifoPop),
        .head     (fifoHead),
        .count    (fifoCount),
        .full     (fifoFull)
    );

    // Registered write port; address and data hold when nothing is selected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            writeEnable <= 1'b0;
            writeAdr    <= '0;
            writeData   <= '0;
        end else begin
            writeEnable <= (selSrc != SRC_NONE);
            if (selSrc != SRC_NONE) begin
                writeAdr  <= selReq.adr;
                writeData <= selReq.data;
            end
        end
    end

    // Only load writes retire a pending bit.  The issue set is applied after
    // the clear so a same-cycle re-issue to the same register stays pending.
    assign clearEn = (selSrc == SRC_FIFO) || (selSrc == SRC_BYPASS);

    always_comb begin
        pendNext = pendingMask;
        if (clearEn) begin
            pendNext[selReq.adr] = 1'b0;
        end
        if (issueValid) begin
            pendNext[issueAdr] = 1'b1;
        end
    end

    // Pending-load scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendingMask <= '0;
        end else begin
            pendingMask <= pendNext;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter.  A queue-based model of the
// write port predicts every register-file write; a monitor pops those
// predictions whenever the DUT raises writeEnable.
module tb_writeback_arbiter;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        aluValid;
    logic [5:0]  aluAdr;
    logic [63:0] aluData;
    logic        memValid;
    logic        memReady;
    logic [5:0]  memAdr;
    logic [63:0] memData;
    logic        issueValid;
    logic [5:0]  issueAdr;
    logic [5:0]  writeAdr;
    logic [63:0] writeData;
    logic        writeEnable;
    logic [63:0] pendingMask;

    int nChecks = 0;
    int nFail   = 0;

    wb_req_t     expQ[$];
    wb_req_t     loadQ[$];
    logic [63:0] modelPend = '0;
    bit          readyArmed = 1'b0;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DEPTH       (DEPTH),
        .ADR_W       (6),
        .DATA_W      (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .aluValid    (aluValid),
        .aluAdr      (aluAdr),
        .aluData     (aluData),
        .memValid    (memValid),
        .memReady    (memReady),
        .memAdr      (memAdr),
        .memData     (memData),
        .issueValid  (issueValid),
        .issueAdr    (issueAdr),
        .writeAdr    (writeAdr),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .pendingMask (pendingMask)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
        end
    endtask

    // One cycle: check scoreboard, drive inputs, predict the write and the
    // model state that results from this cycle's handshake.
    task automatic applyStimulus(input bit aV, input logic [5:0] aA, input logic [63:0] aD,
                                 input bit mV, input logic [5:0] mA, input logic [63:0] mD,
                                 input bit iV, input logic [5:0] iA);
        bit      expReady;
        bit      accept;
        wb_req_t w;
        @(negedge clk);
        checkOutput("pendingMask", pendingMask, modelPend);
        aluValid   = aV;
        aluAdr     = aA;
        aluData    = aD;
        memValid   = mV;
        memAdr     = mA;
        memData    = mD;
        issueValid = iV;
        issueAdr   = iA;
        #1;
        expReady = readyArmed && (loadQ.size() < DEPTH);
        checkOutput("memReady", {63'd0, memReady}, {63'd0, expReady});
        accept = mV && expReady;
        if (aV) begin
            expQ.push_back(makeReq(aA, aD));
            if (accept) loadQ.push_back(makeReq(mA, mD));
        end else if (loadQ.size() > 0) begin
            w = loadQ.pop_front();
            expQ.push_back(w);
            modelPend[w.adr] = 1'b0;
            if (accept) loadQ.push_back(makeReq(mA, mD));
        end else if (accept) begin
            expQ.push_back(makeReq(mA, mD));
            modelPend[mA] = 1'b0;
        end
        if (iV) modelPend[iA] = 1'b1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0);
    endtask

    task automatic releaseReset();
        rst = 1'b0;
        readyArmed = 1'b0;
        #1;
        checkOutput("readyAfterRelease", {63'd0, memReady}, 64'd0);
        readyArmed = 1'b1;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        aluValid   = 1'b0;
        memValid   = 1'b0;
        issueValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstWriteEnable", {63'd0, writeEnable}, 64'd0);
        checkOutput("rstWriteAdr", {58'd0, writeAdr}, 64'd0);
        checkOutput("rstWriteData", writeData, 64'd0);
        checkOutput("rstPendingMask", pendingMask, 64'd0);
        checkOutput("rstMemReady", {63'd0, memReady}, 64'd0);
        expQ.delete();
        loadQ.delete();
        modelPend = '0;
        repeat (2) @(negedge clk);
        releaseReset();
    endtask

    // Monitor: every DUT write must match the oldest predicted write.
    initial begin
        wb_req_t e;
        forever begin
            @(negedge clk);
            if (!rst && writeEnable) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("[TB] FAIL unexpectedWrite: actual adr %0d data %h required no write",
                             writeAdr, writeData);
                end else begin
                    e = expQ.pop_front();
                    if (writeAdr !== e.adr || writeData !== e.data) begin
                        nFail++;
                        $display("[TB] FAIL writePort: actual adr %0d data %h required adr %0d data %h",
                                 writeAdr, writeData, e.adr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        aluValid   = 1'b0;
        aluAdr     = '0;
        aluData    = '0;
        memValid   = 1'b0;
        memAdr     = '0;
        memData    = '0;
        issueValid = 1'b0;
        issueAdr   = '0;
        #1;
        checkOutput("initWriteEnable", {63'd0, writeEnable}, 64'd0);
        checkOutput("initWriteAdr", {58'd0, writeAdr}, 64'd0);
        checkOutput("initWriteData", writeData, 64'd0);
        checkOutput("initPendingMask", pendingMask, 64'd0);
        checkOutput("initMemReady", {63'd0, memReady}, 64'd0);
        repeat (2) @(negedge clk);
        releaseReset();

        // ALU only
        applyStimulus(1'b1, 6'd5, 64'd42, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0);
        idle();
        checkOutput("aluWe", {63'd0, writeEnable}, 64'd1);
        checkOutput("aluAdr", {58'd0, writeAdr}, 64'd5);
        checkOutput("aluData", writeData, 64'd42);
        idle();
        checkOutput("aluWeOff", {63'd0, writeEnable}, 64'd0);

        // Load bypass
        applyStimulus(1'b0, 6'd0, 64'd0, 1'b1, 6'd3, 64'd7, 1'b0, 6'd0);
        idle();
        checkOutput("bypassAdr", {58'd0, writeAdr}, 64'd3);
        checkOutput("bypassData", writeData, 64'd7);

        // ALU vs load conflict
        applyStimulus(1'b1, 6'd1, 64'd10, 1'b1, 6'd2, 64'd20, 1'b0, 6'd0);
        idle();
        checkOutput("conflictFirst", {58'd0, writeAdr}, 64'd1);
        idle();
        checkOutput("conflictSecondAdr", {58'd0, writeAdr}, 64'd2);
        checkOutput("conflictSecondData", writeData, 64'd20);

        // Backpressure: ALU busy four cycles, loads offered every cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 6'(20 + i), 64'(100 + i), 1'b1, 6'(30 + i), 64'(200 + i), 1'b0, 6'd0);
        end
        checkOutput("fullNotReady", {63'd0, memReady}, 64'd0);
        repeat (4) idle();

        // Scoreboard set / clear / same-cycle re-issue
        applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd9);
        idle();
        checkOutput("pend9Set", {63'd0, pendingMask[9]}, 64'd1);
        applyStimulus(1'b0, 6'd0, 64'd0, 1'b1, 6'd9, 64'd55, 1'b0, 6'd0);
        idle();
        checkOutput("pend9Clear", {63'd0, pendingMask[9]}, 64'd0);
        applyStimulus(1'b0, 6'd0, 64'd0, 1'b0, 6'd0, 64'd0, 1'b1, 6'd9);
        applyStimulus(1'b0, 6'd0, 64'd0, 1'b1, 6'd9, 64'd66, 1'b1, 6'd9);
        idle();
        checkOutput("pend9Reissue", {63'd0, pendingMask[9]}, 64'd1);
        applyStimulus(1'b1, 6'd4, 64'd4, 1'b0, 6'd0, 64'd0, 1'b0, 6'd0);
        idle();
        checkOutput("pend9AluNoClear", {63'd0, pendingMask[9]}, 64'd1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 4), 6'($urandom_range(0, 63)), {$urandom(), $urandom()},
                          ($urandom_range(0, 1) == 1), 6'($urandom_range(0, 63)), {$urandom(), $urandom()},
                          ($urandom_range(0, 9) < 3), 6'($urandom_range(0, 63)));
        end
        repeat (4) idle();

        // Reset mid-operation with two loads buffered
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 6'(40 + i), 64'(300 + i), 1'b1, 6'(50 + i), 64'(400 + i), 1'b1, 6'(50 + i));
        end
        resetPulse();
        repeat (4) idle();
        applyStimulus(1'b0, 6'd0, 64'd0, 1'b1, 6'd12, 64'd99, 1'b0, 6'd0);
        repeat (3) idle();

        checkOutput("leftoverWrites", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer side of the 64x64 register-file write port.
- Merges two result sources into the single writeAdr/writeData/writeEnable port:
  - single-cycle ALU results, which have no backpressure;
  - multi-cycle load results, which use a valid/ready handshake.
- Load results that lose arbitration are buffered in a small FIFO.
- A pending-load scoreboard tells issue logic which registers still await a load.

Parameters:
- DEPTH, 2, load-result FIFO entries (power of two, ≥2).
- ADR_W, 6, register address width (64 registers).
- DATA_W, 64, register data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- aluValid  in  1  ALU result present this cycle; always accepted.
- aluAdr  in  ADR_W  ALU destination register.
- aluData  in  DATA_W  ALU result.
- memValid  in  1  load result offered.
- memReady  out  1  load result accepted when memValid && memReady.
- memAdr  in  ADR_W  load destination register.
- memData  in  DATA_W  load result.
- issueValid  in  1  a load to issueAdr was issued this cycle.
- issueAdr  in  ADR_W  destination of the issued load.
- writeAdr  out  ADR_W  register-file write address (registered).
- writeData  out  DATA_W  register-file write data (registered).
- writeEnable  out  1  register-file write strobe (registered).
- pendingMask  out  2**ADR_W  bit i = load to register i outstanding.

Behaviour:
- Reset (async, immediate): writeEnable=0, writeAdr=0, writeData=0, pendingMask=0, FIFO count=0, read and write pointers=0, memReady=1 one cycle after rst falls. While rst=1, memReady=0.
- Latency: a result selected in cycle N appears on writeAdr/writeData with writeEnable=1 in cycle N+1, giving one write per cycle.
- Priority per cycle:
  - aluValid beats the FIFO head, and the FIFO head beats a live memValid.
  - With no ALU result, the FIFO head is written if the FIFO is non-empty; otherwise an accepted load is written directly (bypass; it is not enqueued).
  - If nothing is selected, writeEnable=0 next cycle and writeAdr/writeData hold their previous values.
- An accepted load that is not written this cycle is enqueued. An accepted load is never written and enqueued in the same cycle.
- memReady = (count < DEPTH), combinational from the registered count only; it does not depend on memValid.
- FIFO full, with the head draining in the same cycle: memReady stays 0 that cycle (conservative); a new load can be accepted next cycle.
- FIFO empty with aluValid=1 and an accepted load: the load is enqueued and count becomes 1.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH or underflows; an assertion flags a violation.
- Ordering:
  - Loads are written in acceptance order.
  - ALU and load writes to the same address resolve in write-port order.
  - WAW avoidance is the job of the issue logic, which consults pendingMask.
- Scoreboard:
  - issueValid sets pendingMask[issueAdr] at the next edge.
  - Writing a load result (from the FIFO head or the bypass) clears its bit at the same edge it is selected.
  - Set and clear of the same bit in the same cycle: set wins.
  - ALU writes never change pendingMask.
- Reset mid-operation discards FIFO contents and pending bits. No partial write is emitted.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ADR_W=6 and REG_DATA_W=64;
  - the typedef wb_req_t {adr, data}, used by the FIFO and by the register-file write side.
- One natural sub-module: wb_fifo, parameterised by DEPTH and storing wb_req_t, exposing push, pop, head, count and full.
- The arbiter, the output register and the scoreboard stay in writeback_arbiter.

Test Plan:
- ALU only: aluValid=1, aluAdr=5, aluData=42 in cycle 0 → cycle 1 shows writeEnable=1, writeAdr=5, writeData=42; cycle 2 shows writeEnable=0.
- Load bypass: FIFO empty, memValid=1, memAdr=3, memData=7, no ALU → accepted, written next cycle, FIFO count stays 0.
- Conflict: aluValid (adr 1, data 10) and memValid (adr 2, data 20) in the same cycle → write adr1/10 then adr2/20 on consecutive cycles.
- Backpressure:
  - ALU busy 4 cycles while loads are offered each cycle → memReady drops after 2 accepts.
  - Loads drain in acceptance order once the ALU idles.
  - No load is lost or duplicated.
- Scoreboard:
  - issueValid with issueAdr=9 → pendingMask[9]=1.
  - A load to 9 writes back → bit 9 clears.
  - A same-cycle re-issue to 9 leaves bit 9 set.
- Async reset: rst pulsed mid-cycle with FIFO count=2 → outputs and pendingMask go to 0 immediately, and no stale write appears after release.
